spi_master_arbiter: RTL

//  Shares one spi_master byte engine among NUM_REQ requesters (e.g. CPU reg path, XIP/DMA).

---
 rtl/spi_master_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin frame arbiter sharing one spi_master byte engine
// Optional per-byte watchdog with err_o reporting: define SPI_ARB_TIMEOUT_EN.

module spi_master_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int LEN_W    = 8,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       req_read_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  input  logic [NUM_REQ*8-1:0]     tx_data_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       tx_ack_o,
  output logic [7:0]               rx_data_o,
  output logic [NUM_REQ-1:0]       rx_valid_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic                     m_start_o,
  output logic                     m_read_o,
  output logic [7:0]               m_data_o,
  input  logic                     m_ready_i,
  input  logic                     m_data_valid_i,
  input  logic [7:0]               m_data_i,
  output logic                     m_ss_sw_ctrl_o,
  output logic                     m_ss_level_o
);

  localparam int         IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] SETUP_LAST = (SS_SETUP == 0) ? 4'd0 : 4'(SS_SETUP - 1);
  localparam logic [3:0] HOLD_LAST  = (SS_HOLD == 0) ? 4'd0 : 4'(SS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SETUP, S_LAUNCH, S_WAIT, S_HOLD, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, last_q, pick_idx, cand;
  logic             pick_valid;
  logic [LEN_W-1:0] remaining_q;
  logic [3:0]       cnt_q;
  logic             dv_prev_q, dv_edge;
  logic [7:0]       tx_arr [NUM_REQ];
  logic [LEN_W-1:0] len_arr [NUM_REQ];

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign tx_arr[g]  = tx_data_i[8*g +: 8];
      assign len_arr[g] = req_len_i[LEN_W*g +: LEN_W];
    end
  endgenerate

  assign m_ss_sw_ctrl_o = 1'b1;
  // Only a fresh 0->1 edge completes a byte; a level left high from the previous byte is ignored.
  assign dv_edge        = m_data_valid_i & ~dv_prev_q;
  assign done_o         = (state_q == S_DONE) ? gnt_o : '0;

  // Scanning k downward lets the smallest offset after last_q win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_hit, abort;
  assign wd_hit = (wd_q == WD_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
`ifdef SPI_ARB_TIMEOUT_EN
    abort   = 1'b0;
`endif
    case (state_q)
      S_IDLE:   if (|req_i) state_d = S_ARB;
      S_ARB: begin
        if (!pick_valid)                   state_d = S_IDLE;
        else if (len_arr[pick_idx] == '0)  state_d = S_DONE;
        else                               state_d = S_SETUP;
      end
      S_SETUP:  if (cnt_q >= SETUP_LAST) state_d = S_LAUNCH;
      S_LAUNCH: begin
        if (m_ready_i) state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_hit) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_WAIT: begin
        if (dv_edge) state_d = (remaining_q == '0) ? S_HOLD : S_LAUNCH;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_hit) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_HOLD:   if (cnt_q >= HOLD_LAST) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_o        <= '0;
      idx_q        <= '0;
      last_q       <= IDX_W'(NUM_REQ - 1);
      remaining_q  <= '0;
      cnt_q        <= '0;
      dv_prev_q    <= 1'b0;
      tx_ack_o     <= '0;
      rx_valid_o   <= '0;
      rx_data_o    <= '0;
      m_start_o    <= 1'b0;
      m_read_o     <= 1'b0;
      m_data_o     <= '0;
      m_ss_level_o <= 1'b1;
    end else begin
      m_start_o  <= 1'b0;
      tx_ack_o   <= '0;
      rx_valid_o <= '0;
      dv_prev_q  <= m_data_valid_i;
      cnt_q      <= (state_d == state_q) ? cnt_q + 4'd1 : 4'd0;
      case (state_q)
        S_ARB: if (pick_valid) begin
          gnt_o       <= NUM_REQ'(1) << pick_idx;
          idx_q       <= pick_idx;
          remaining_q <= len_arr[pick_idx];
          m_read_o    <= req_read_i[pick_idx];
          if (len_arr[pick_idx] != '0) m_ss_level_o <= 1'b0;
        end
        S_LAUNCH: if (m_ready_i) begin
          m_start_o <= 1'b1;
          m_data_o  <= tx_arr[idx_q];
          tx_ack_o  <= gnt_o;
          if (remaining_q != '0) remaining_q <= remaining_q - LEN_W'(1);
        end
        S_WAIT: if (dv_edge && m_read_o) begin
          rx_data_o  <= m_data_i;
          rx_valid_o <= gnt_o;
        end
        S_HOLD: if (state_d == S_DONE) m_ss_level_o <= 1'b1;
        S_DONE: begin
          gnt_o  <= '0;
          last_q <= idx_q;
        end
        default: ;
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      if (abort) begin
        m_ss_level_o <= 1'b1;
        gnt_o        <= '0;
        last_q       <= idx_q;
      end
`endif
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Watchdog restarts on every state change, so each LAUNCH and each byte gets a fresh budget.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_o <= '0;
    end else begin
      err_o <= abort ? gnt_o : '0;
      wd_q  <= (state_d != state_q) ? '0 : wd_q + WD_W'(1);
    end
  end
`else
  assign err_o = '0;
`endif

endmodule
